uni_bitstream_counter: RTL and testbench
========================================

# uni_bitstream_counter

Unipolar stochastic-to-binary converter: counts 1s in a unipolar bitstream over a fixed window of 2^WINLOG valid bits and returns the scaled binary value. It sits at the output of stochastic compute units such as the unipolar multiplier, converting their output stream back to a DATAWD-bit binary word. Conversion is started by a start pulse, and the result is returned over a valid/ready handshake.

## Interface
- DATAWD, default `INWD (8 in benches): binary result width.
- WINLOG, default DATAWD: log2 of the window length in valid stream bits. Legal range is 1 ≤ WINLOG ≤ DATAWD.

- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  one clock; reset is asynchronous and active-low.
- start  in  1  begin a conversion. Accepted only in IDLE, or in DONE on the cycle the result handshake completes.
- clear  in  1  synchronous abort. Returns the block to IDLE and zeroes the counters. Has priority over all other inputs except rst_n.
- iStream  in  1  stochastic bit.
- iValid  in  1  qualifies iStream. A cycle with iValid=0 is neither counted nor advances the window.
- oData  out  DATAWD  converted value. Held stable while oValid=1.
- oValid  out  1  result available.
- iReady  in  1  consumer accepts the result when oValid & iReady.
- busy  out  1  high in ACC.

## Operation
- States: IDLE, ACC, DONE.
- IDLE:
  - busy=0, oValid=0.
  - start=1 → ACC, with the bit counter (WINLOG+1 bits) and ones counter (WINLOG+1 bits) zeroed.
- ACC:
  - Each cycle with iValid=1: the bit counter increments; the ones counter increments if iStream=1.
  - When a valid bit is accepted while the bit counter equals 2^WINLOG−1, that bit is included and the state goes to DONE.
  - start is ignored in ACC.
- Result, registered into oData on the ACC→DONE transition:
  - ones << (DATAWD−WINLOG), truncated to DATAWD bits.
  - If ones == 2^WINLOG (all bits 1), oData saturates to 2^DATAWD−1.
- DONE:
  - oValid=1 and oData is held.
  - On oValid & iReady: go to ACC (counters zeroed) if start=1 on the same cycle, else go to IDLE.
  - With iReady=0, the block holds in DONE indefinitely.
  - start without iReady is ignored.
- clear in any state: next state IDLE, counters=0, oValid=0. oData keeps its last value (don't-care while oValid=0).
- The iStream value is ignored when iValid=0 and outside ACC.

## Timing
- Reset values: state IDLE, oData=0, oValid=0, busy=0, counters=0.
- start sampled at edge t → busy=1 from t. The first countable bit is the one presented for edge t+1.
- With continuous iValid, the last window bit is sampled at edge t+2^WINLOG, and oValid=1 from that same edge. Start-to-valid latency is 2^WINLOG cycles, plus one cycle for each iValid=0 cycle.
- Back-to-back conversions: a handshake together with start at edge u puts the block in ACC at u. There are no idle cycles between windows.
- rst_n asserted mid-ACC or mid-DONE immediately forces reset values. The partial count and any pending result are discarded.
- clear and start in the same cycle: clear wins, giving IDLE. start must be reissued.
- iValid=1 and clear in the same cycle: the bit is not counted.

## Test plan
- DATAWD=8, WINLOG=8, start then 256 cycles of iStream=1 → oValid rises after 256 cycles with oData=255 (saturated). busy=0 afterwards.
- DATAWD=8, WINLOG=8, alternating 1,0 for 256 cycles → oData=128. An all-zero stream → oData=0.
- DATAWD=8, WINLOG=4, 5 ones in 16 valid bits with iValid randomly deasserted for 7 interleaved cycles → oData=80, oValid at 23 cycles after start.
- Backpressure: iReady=0 for 20 cycles after oValid → oData and oValid are stable throughout. start pulses during the hold are ignored. iReady=1 together with start → the next window begins immediately and yields the correct second result.
- Abort: clear at bit 100 of a window → IDLE next cycle with oValid=0. A fresh start produces a correct, uncorrupted count. start during ACC is ignored (window length unchanged).
- Reset: rst_n low asynchronously (between edges) mid-ACC → outputs go to reset values without waiting for clk. After release, a start plus 256 ones → oData=255.

Source files
------------

// File: rtl/uni_bitstream_counter_if.sv
// Stream/result bundle for the unipolar bitstream counter.
// The slave side is the converter; the master side is whoever drives the
// stream and consumes the result.
`ifndef INWD
`define INWD 8
`endif

interface uni_bitstream_counter_if #(
  parameter int DATAWD = `INWD
) ();
  logic              start;
  logic              clear;
  logic              iStream;
  logic              iValid;
  logic [DATAWD-1:0] oData;
  logic              oValid;
  logic              iReady;
  logic              busy;

  modport slave (
    input  start, clear, iStream, iValid, iReady,
    output oData, oValid, busy
  );

  modport master (
    output start, clear, iStream, iValid, iReady,
    input  oData, oValid, busy
  );
endinterface

// File: rtl/uni_bitstream_counter.sv
// Unipolar stochastic-to-binary converter. Counts the ones in a window of
// 2^WINLOG valid stream bits and returns the count scaled to DATAWD bits.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start, no result pending
//   ACC   | accumulating valid bits of the current window (busy=1)
//   DONE  | result held on oData with oValid=1 until iReady
`ifndef INWD
`define INWD 8
`endif

module uni_bitstream_counter #(
  parameter int DATAWD = `INWD,
  parameter int WINLOG = DATAWD
) (
  input  logic                    clk,
  input  logic                    rst_n,
  uni_bitstream_counter_if.slave  bus
);

  localparam int SHIFT = DATAWD - WINLOG;
  // Full window: a ones count equal to this means every bit was 1.
  localparam logic [WINLOG:0] WIN_LEN  = {1'b1, {WINLOG{1'b0}}};
  localparam logic [WINLOG:0] LAST_IDX = {1'b0, {WINLOG{1'b1}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WINLOG:0]   bit_cnt;
  logic [WINLOG:0]   ones_cnt;
  logic [WINLOG:0]   ones_final;
  logic [DATAWD:0]   ones_ext;
  logic [DATAWD-1:0] scaled;
  logic              take_bit;
  logic              last_bit;
  logic              restart;

  // clear suppresses counting even when iValid is high on the same cycle.
  assign take_bit   = (state == ACC) && bus.iValid && !bus.clear;
  assign last_bit   = take_bit && (bit_cnt == LAST_IDX);
  // Ones count including the bit being accepted this cycle.
  assign ones_final = ones_cnt + {{WINLOG{1'b0}}, bus.iStream};
  assign ones_ext   = (DATAWD+1)'(ones_final);
  assign scaled     = DATAWD'(ones_ext << SHIFT);
  // Entering ACC from IDLE or from a DONE handshake starts a fresh window.
  assign restart    = (state_nxt == ACC) && (state != ACC);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; clear overrides everything.
  always_comb begin
    state_nxt = state;
    if (bus.clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (bus.start) state_nxt = ACC;
        ACC:  if (last_bit)  state_nxt = DONE;
        DONE: if (bus.iReady) state_nxt = bus.start ? ACC : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Window bit counter and ones counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      ones_cnt <= '0;
    end else if (bus.clear || restart) begin
      bit_cnt  <= '0;
      ones_cnt <= '0;
    end else if (take_bit) begin
      bit_cnt  <= bit_cnt + 1'b1;
      ones_cnt <= ones_final;
    end
  end

  // Result capture on the last window bit; a full window saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.oData <= '0;
    end else if (last_bit) begin
      bus.oData <= (ones_final == WIN_LEN) ? {DATAWD{1'b1}} : scaled;
    end
  end

  // Status outputs decoded from state.
  always_comb begin
    bus.oValid = (state == DONE);
    bus.busy   = (state == ACC);
  end

endmodule

// File: tb/tb_uni_bitstream_counter.sv
// Testbench for uni_bitstream_counter: an 8/8 instance and an 8/4 instance
// driven with random streams and checked against a count-and-scale model.
module tb_uni_bitstream_counter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  uni_bitstream_counter_if #(.DATAWD(8)) ifa ();
  uni_bitstream_counter_if #(.DATAWD(8)) ifb ();

  uni_bitstream_counter #(.DATAWD(8), .WINLOG(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave)
  );
  uni_bitstream_counter #(.DATAWD(8), .WINLOG(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave)
  );

  // Reference: count of ones over the window, scaled to 8 bits, saturating.
  function automatic logic [7:0] model(input int ones, input int winlog);
    if (ones == (1 << winlog)) return 8'hFF;
    return 8'((ones << (8 - winlog)) & 255);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one 256-bit window into dut_a. mode: 0 zeros, 1 ones,
  // 2 alternating 1/0, 3 random. start_at pulses start at that bit index.
  task automatic run_a(input int mode, input int gap_pct, input int start_at,
                       input bit do_start, output int ones, output bit early);
    int nbits;
    bit v, b;
    nbits = 0;
    ones = 0;
    early = 0;
    if (do_start) begin
      ifa.start = 1;
      tick();
      ifa.start = 0;
    end
    while (nbits < 256) begin
      v = ($urandom_range(99) >= gap_pct);
      case (mode)
        0: b = 0;
        1: b = 1;
        2: b = (nbits % 2 == 0);
        default: b = 1'($urandom_range(1));
      endcase
      ifa.iValid  = v;
      ifa.iStream = v ? b : 1'($urandom_range(1));
      ifa.start   = (nbits == start_at);
      tick();
      if (v) begin
        nbits++;
        ones += int'(b);
      end
      if (nbits < 256 && ifa.oValid) early = 1;
    end
    ifa.iValid = 0;
    ifa.start  = 0;
  endtask

  task automatic ack_a();
    ifa.iReady = 1;
    tick();
    ifa.iReady = 0;
  endtask

  task automatic test_reset();
    n_cmp++; if (ifa.oValid !== 1'b0 || ifa.busy !== 1'b0) begin n_err++;
      $display("FAIL reset_a_flags: got valid=%b busy=%b want 0 0", ifa.oValid, ifa.busy); end
    n_cmp++; if (ifa.oData !== 8'h00) begin n_err++;
      $display("FAIL reset_a_data: got %0d want 0", ifa.oData); end
    n_cmp++; if (ifb.oValid !== 1'b0 || ifb.busy !== 1'b0 || ifb.oData !== 8'h00) begin n_err++;
      $display("FAIL reset_b: got valid=%b busy=%b data=%0d want 0 0 0", ifb.oValid, ifb.busy, ifb.oData); end
  endtask

  task automatic test_patterns();
    int ones;
    bit early;
    logic [7:0] exp;
    for (int m = 0; m < 3; m++) begin
      int mode;
      mode = (m == 0) ? 1 : (m == 1) ? 2 : 0;
      run_a(mode, 0, -1, 1, ones, early);
      exp = model(ones, 8);
      n_cmp++; if (early !== 1'b0 || ifa.oValid !== 1'b1) begin n_err++;
        $display("FAIL pat%0d_latency: got early=%b valid=%b want 0 1", mode, early, ifa.oValid); end
      n_cmp++; if (ifa.oData !== exp) begin n_err++;
        $display("FAIL pat%0d_data: got %0d want %0d", mode, ifa.oData, exp); end
      ack_a();
      n_cmp++; if (ifa.oValid !== 1'b0 || ifa.busy !== 1'b0) begin n_err++;
        $display("FAIL pat%0d_after: got valid=%b busy=%b want 0 0", mode, ifa.oValid, ifa.busy); end
    end
  endtask

  task automatic test_random_gaps();
    int ones;
    bit early;
    logic [7:0] exp;
    for (int r = 0; r < 4; r++) begin
      run_a(3, 25, -1, 1, ones, early);
      exp = model(ones, 8);
      n_cmp++; if (early !== 1'b0 || ifa.oValid !== 1'b1 || ifa.oData !== exp) begin n_err++;
        $display("FAIL rand%0d: got early=%b valid=%b data=%0d want 0 1 %0d",
                 r, early, ifa.oValid, ifa.oData, exp); end
      ack_a();
    end
  endtask

  task automatic test_short_window();
    for (int r = 0; r < 2; r++) begin
      bit gap [23];
      bit one [16];
      int k, cnt, p, vi, ones;
      logic [7:0] exp;
      k = (r == 0) ? 5 : $urandom_range(16);
      foreach (gap[i]) gap[i] = 0;
      foreach (one[i]) one[i] = 0;
      cnt = 0;
      while (cnt < 7) begin
        p = $urandom_range(21);
        if (!gap[p]) begin gap[p] = 1; cnt++; end
      end
      cnt = 0;
      while (cnt < k) begin
        p = $urandom_range(15);
        if (!one[p]) begin one[p] = 1; cnt++; end
      end
      ones = k;
      exp = model(ones, 4);
      ifb.start = 1;
      tick();
      ifb.start = 0;
      vi = 0;
      for (int s = 0; s < 23; s++) begin
        ifb.iValid  = !gap[s];
        ifb.iStream = gap[s] ? 1'b1 : one[vi];
        tick();
        if (!gap[s]) vi++;
        if (s == 21) begin
          n_cmp++; if (ifb.oValid !== 1'b0) begin n_err++;
            $display("FAIL short%0d_early: got valid=%b at cycle 22 want 0", r, ifb.oValid); end
        end
      end
      ifb.iValid = 0;
      n_cmp++; if (ifb.oValid !== 1'b1 || ifb.oData !== exp) begin n_err++;
        $display("FAIL short%0d_result: got valid=%b data=%0d want 1 %0d", r, ifb.oValid, ifb.oData, exp); end
      ifb.iReady = 1;
      tick();
      ifb.iReady = 0;
      n_cmp++; if (ifb.oValid !== 1'b0 || ifb.busy !== 1'b0) begin n_err++;
        $display("FAIL short%0d_after: got valid=%b busy=%b want 0 0", r, ifb.oValid, ifb.busy); end
    end
  endtask

  task automatic test_back_to_back();
    int ones, bad;
    bit early;
    logic [7:0] exp;
    run_a(3, 0, -1, 1, ones, early);
    exp = model(ones, 8);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      ifa.start = 1'($urandom_range(1));
      tick();
      if (ifa.oValid !== 1'b1 || ifa.oData !== exp || ifa.busy !== 1'b0) bad++;
    end
    n_cmp++; if (bad != 0) begin n_err++;
      $display("FAIL hold: got %0d unstable cycles want 0 (data=%0d exp=%0d)", bad, ifa.oData, exp); end
    ifa.iReady = 1;
    ifa.start  = 1;
    tick();
    ifa.iReady = 0;
    ifa.start  = 0;
    n_cmp++; if (ifa.busy !== 1'b1 || ifa.oValid !== 1'b0) begin n_err++;
      $display("FAIL b2b_start: got busy=%b valid=%b want 1 0", ifa.busy, ifa.oValid); end
    run_a(3, 10, -1, 0, ones, early);
    exp = model(ones, 8);
    n_cmp++; if (early !== 1'b0 || ifa.oValid !== 1'b1 || ifa.oData !== exp) begin n_err++;
      $display("FAIL b2b_second: got early=%b valid=%b data=%0d want 0 1 %0d",
               early, ifa.oValid, ifa.oData, exp); end
    ack_a();
  endtask

  task automatic test_abort();
    int ones;
    bit early;
    logic [7:0] exp;
    ifa.start = 1;
    tick();
    ifa.start = 0;
    for (int i = 0; i < 100; i++) begin
      ifa.iValid = 1; ifa.iStream = 1; tick();
    end
    ifa.clear = 1;
    tick();
    ifa.clear = 0; ifa.iValid = 0;
    n_cmp++; if (ifa.busy !== 1'b0 || ifa.oValid !== 1'b0) begin n_err++;
      $display("FAIL abort_idle: got busy=%b valid=%b want 0 0", ifa.busy, ifa.oValid); end
    ifa.clear = 1; ifa.start = 1;
    tick();
    ifa.clear = 0; ifa.start = 0;
    tick();
    n_cmp++; if (ifa.busy !== 1'b0) begin n_err++;
      $display("FAIL clear_start: got busy=%b want 0", ifa.busy); end
    run_a(3, 10, 50, 1, ones, early);
    exp = model(ones, 8);
    n_cmp++; if (early !== 1'b0 || ifa.oValid !== 1'b1 || ifa.oData !== exp) begin n_err++;
      $display("FAIL abort_fresh: got early=%b valid=%b data=%0d want 0 1 %0d",
               early, ifa.oValid, ifa.oData, exp); end
    ifa.clear = 1;
    tick();
    ifa.clear = 0;
    n_cmp++; if (ifa.oValid !== 1'b0 || ifa.busy !== 1'b0) begin n_err++;
      $display("FAIL clear_done: got valid=%b busy=%b want 0 0", ifa.oValid, ifa.busy); end
  endtask

  task automatic test_async_reset();
    int ones;
    bit early;
    ifa.start = 1;
    tick();
    ifa.start = 0;
    for (int i = 0; i < 60; i++) begin
      ifa.iValid = 1; ifa.iStream = 1'($urandom_range(1)); tick();
    end
    ifa.iValid = 0;
    #3 rst_n = 0;
    #1;
    n_cmp++; if (ifa.busy !== 1'b0 || ifa.oValid !== 1'b0 || ifa.oData !== 8'h00) begin n_err++;
      $display("FAIL async_reset: got busy=%b valid=%b data=%0d want 0 0 0",
               ifa.busy, ifa.oValid, ifa.oData); end
    #2 rst_n = 1;
    tick();
    run_a(1, 0, -1, 1, ones, early);
    n_cmp++; if (early !== 1'b0 || ifa.oValid !== 1'b1 || ifa.oData !== model(ones, 8)) begin n_err++;
      $display("FAIL reset_rerun: got early=%b valid=%b data=%0d want 0 1 255",
               early, ifa.oValid, ifa.oData); end
    ack_a();
  endtask

  initial begin
    ifa.start = 0; ifa.clear = 0; ifa.iStream = 0; ifa.iValid = 0; ifa.iReady = 0;
    ifb.start = 0; ifb.clear = 0; ifb.iStream = 0; ifb.iValid = 0; ifb.iReady = 0;
    #23;
    test_reset();
    rst_n = 1;
    tick();
    test_patterns();
    test_random_gaps();
    test_short_window();
    test_back_to_back();
    test_abort();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
